hs_rr_arbiter: RTL and testbench
================================

# hs_rr_arbiter

Round-robin arbiter that shares one valid/ready sink between N valid/ready sources, such as several memory-backed data sources feeding a single consumer. It grants one source at a time for a bounded burst, registers the granted beat in a one-entry output stage, and tags it with the source index. Each handshake follows the team's standard rule: a transfer happens on the rising edge where valid and ready are both high.

## Interface
- `N`, default 4: number of sources, ≥1.
- `WIDTH`, default 8: payload width.
- `BURST`, default 4: maximum beats per grant, ≥1.
- `IDW` (localparam): `max(1, $clog2(N))`.

- `clk`  in  1: clock; the only clock.
- `s_rst`  in  1: synchronous, active-high reset.
- `s_vaild`  in  N: source valid, bit i belongs to source i.
- `s_data`  in  N*WIDTH: source payloads, source i at `[i*WIDTH +: WIDTH]`.
- `s_ready`  out  N: source ready, one-hot or zero.
- `m_vaild`  out  1: output beat valid.
- `m_data`  out  WIDTH: output payload.
- `m_id`  out  IDW: index of the source that produced the current output beat.
- `m_ready`  in  1: sink ready.

## Operation
- State machine with two states.
  - IDLE: no grant; `s_ready = 0`.
    - If any `s_vaild` is high, the grant goes to the first set bit at or after `ptr`, searching upward with wrap at N.
    - The machine then enters BUSY with `gnt` = that source and `cnt = 0`.
  - BUSY: `s_ready[gnt] = ~m_vaild | m_ready`; all other `s_ready` bits are 0.
    - A transfer occurs when `s_vaild[gnt] & s_ready[gnt]`. It loads `m_data ← s_data[gnt]`, `m_id ← gnt`, `m_vaild ← 1`, and increments `cnt`.
    - The grant is released after the transfer where `cnt == BURST-1`.
    - The grant is also released in any BUSY cycle where `s_vaild[gnt] == 0`; no transfer happens in that cycle.
    - On release: `ptr ← (gnt+1) mod N`, next state IDLE.
- Output register:
  - If `m_vaild & m_ready` and there is no load, `m_vaild ← 0`.
  - A load and a drain in the same cycle keep `m_vaild = 1` with the new data.
  - `m_data` and `m_id` hold whenever there is no load.
- `cnt` width is `$clog2(BURST+1)`. `ptr` wrap is computed modulo N and is correct for non-power-of-2 N.
- Reset values: state IDLE; `ptr`, `gnt`, `cnt` = 0; `m_vaild`, `m_data`, `m_id` = 0; `s_ready` = 0.
- `s_rst` asserted mid-burst discards any pending output beat. The source beat in that cycle is not accepted.

## Timing
- One arbitration cycle (IDLE) precedes every grant. The first beat can be accepted in the first BUSY cycle.
- Latency from the source transfer edge to `m_vaild` is 1 cycle.
- `s_ready` depends combinationally on `m_ready`. There is no combinational path from `s_vaild` to `s_ready`.
- Throughput is BURST beats per BURST+1 cycles under continuous traffic with `m_ready = 1`.
- Requests that arrive in the same cycle as a release are arbitrated in the following IDLE cycle.
- With N=1, the arbiter alternates IDLE and BUSY with the same source.

## Structure
- Package `hs_pkg`:
  - state typedef {IDLE, BUSY};
  - `idw(n)` width function;
  - shared handshake constants.
- Sub-module `hs_rr_pick`: combinational rotating-priority picker.
  - Inputs: `req[N]` and `ptr`.
  - Outputs: `any` and `idx`.
- The top level holds the FSM, counter, pointer and output register.

## Test plan
All scenarios use N=4, WIDTH=8, BURST=4.

1. Reset: hold `s_rst` for 2 cycles with random inputs.
   - Expect `m_vaild=0`, `m_data=0`, `m_id=0`, `s_ready=0`.
   - The first grant after release goes to source 0 when all sources request.
2. Single source: source 1 continuously valid with data 0x10, 0x11, ..., and `m_ready=1`.
   - Expect 1 IDLE cycle, then `m_id=1` with beats 0x10–0x13.
   - Then 1 IDLE cycle, then 0x14–0x17.
3. All four sources valid, `m_ready=1`.
   - Grant order is 0,1,2,3,0, with 4 beats each and `m_id` matching.
   - Expect 20 beats in 25 cycles.
4. Backpressure: hold `m_ready=0` after the first beat is loaded.
   - `m_vaild=1`; `m_data` and `m_id` stay stable; `s_ready=0`.
   - When `m_ready=1` returns, remaining beats flow with none lost or duplicated.
5. Early release: source 2 drops valid after 2 transfers while source 3 is requesting.
   - Source 2's grant ends, `ptr` becomes 3, and source 3 is granted next.
6. Mid-burst reset: assert `s_rst` after beat 2 of a source 0 burst.
   - Next cycle: `m_vaild=0`, state IDLE, `ptr=0`.
   - Arbitration restarts at source 0.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
package hs_pkg;

  // Arbiter FSM: one arbitration cycle, then a bounded grant.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Handshake defaults shared by the arbiter and its users.
  localparam int unsigned DefaultN     = 4;
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultBurst = 4;

  // Index width for n sources; never narrower than one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping at N.
module hs_rr_pick
  import hs_pkg::*;
#(
  parameter int unsigned N   = DefaultN,
  parameter int unsigned IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  // Walk the N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between N sources, with a
// one-entry registered output stage tagged by source index.
module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned BURST = DefaultBurst,
  localparam int unsigned IDW  = idw(N)
) (
  input  logic               clk,
  input  logic               s_rst,
  input  logic [N-1:0]       s_vaild,
  input  logic [N*WIDTH-1:0] s_data,
  output logic [N-1:0]       s_ready,
  output logic               m_vaild,
  output logic [WIDTH-1:0]   m_data,
  output logic [IDW-1:0]     m_id,
  input  logic               m_ready
);

  localparam int unsigned CntW = $clog2(BURST + 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             m_vaild_d;
  logic [WIDTH-1:0] m_data_d;
  logic [IDW-1:0]   m_id_d;

  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic [WIDTH-1:0] src_data [N];
  logic             gnt_ready;
  logic             xfer;

  hs_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req (s_vaild),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Unpack the flat source payload bus.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      src_data[i] = s_data[i*WIDTH +: WIDTH];
    end
  end

  // Granted source sees ready whenever the output slot is empty or draining.
  always_comb begin
    gnt_ready = ~m_vaild | m_ready;
    s_ready   = '0;
    if (state_q == StBusy) s_ready[gnt_q] = gnt_ready;
    xfer      = (state_q == StBusy) && s_vaild[gnt_q] && gnt_ready;
  end

  // Next-state: arbitration, burst counting, pointer advance and output stage.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    m_vaild_d = m_vaild;
    m_data_d  = m_data;
    m_id_d    = m_id;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StBusy;
          gnt_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        // A dropped valid ends the grant without a transfer.
        if (!s_vaild[gnt_q] || (xfer && cnt_q == CntW'(BURST - 1))) begin
          state_d = StIdle;
          ptr_d   = (gnt_q == IDW'(N - 1)) ? '0 : gnt_q + 1'b1;
        end
        if (xfer) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A load wins over a drain so back-to-back beats keep m_vaild high.
    if (xfer) begin
      m_vaild_d = 1'b1;
      m_data_d  = src_data[gnt_q];
      m_id_d    = gnt_q;
    end else if (m_vaild && m_ready) begin
      m_vaild_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      m_vaild <= 1'b0;
      m_data  <= '0;
      m_id    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      m_vaild <= m_vaild_d;
      m_data  <= m_data_d;
      m_id    <= m_id_d;
    end
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Randomized self-checking bench for hs_rr_arbiter against a behavioural model.
module tb_hs_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int B   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           s_rst;
  logic [N-1:0]   s_vaild;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_ready;
  logic           m_vaild;
  logic [W-1:0]   m_data;
  logic [IDW-1:0] m_id;
  logic           m_ready;

  always #5 clk = ~clk;

  hs_rr_arbiter #(
    .N     (N),
    .WIDTH (W),
    .BURST (B)
  ) dut (
    .clk     (clk),
    .s_rst   (s_rst),
    .s_vaild (s_vaild),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_vaild (m_vaild),
    .m_data  (m_data),
    .m_id    (m_id),
    .m_ready (m_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: granted source (-1 = none), beats taken, next search start,
  // and the output slot contents.
  int g     = -1;
  int beats = 0;
  int ptr   = 0;
  bit ov    = 0;
  int od    = 0;
  int oid   = 0;
  int seq [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle; each source sends (id*16 + its own beat count).
  task automatic drive(input bit rst, input logic [N-1:0] vld, input bit mr);
    s_rst   = rst;
    s_vaild = vld;
    m_ready = mr;
    for (int i = 0; i < N; i++) s_data[i*W +: W] = W'(i * 16 + seq[i]);
    #1;
  endtask

  // Compare DUT against the model, advance the model by one edge, move on.
  task automatic cycle();
    logic [N-1:0] er;
    bit load;
    bit drain;
    bit found;
    int j;
    er = '0;
    if (g >= 0 && (!ov || m_ready)) er[g] = 1'b1;
    check("s_ready", 64'(s_ready), 64'(er));
    check("m_vaild", 64'(m_vaild), 64'(ov));
    check("m_data", 64'(m_data), 64'(od));
    check("m_id", 64'(m_id), 64'(oid));

    if (s_rst) begin
      g = -1; beats = 0; ptr = 0; ov = 0; od = 0; oid = 0;
    end else begin
      load  = 0;
      drain = ov && m_ready;
      if (g < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (!found && s_vaild[j]) begin
            found = 1; g = j; beats = 0;
          end
        end
      end else if (!s_vaild[g]) begin
        ptr = (g + 1) % N; g = -1;
      end else if (!ov || m_ready) begin
        load = 1;
        od   = int'(s_data[g*W +: W]);
        oid  = g;
        seq[g]++;
        beats++;
        if (beats == B) begin
          ptr = (g + 1) % N; g = -1;
        end
      end
      if (load) ov = 1;
      else if (drain) ov = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, N'($urandom), 1'($urandom));
      cycle();
    end
  endtask

  initial begin
    int cnt;
    logic [W-1:0] held_d;
    logic [IDW-1:0] held_id;
    logic [N-1:0] vld;
    for (int i = 0; i < N; i++) seq[i] = 0;
    s_rst = 1'b1; s_vaild = '0; s_data = '0; m_ready = 1'b0;
    @(negedge clk);

    // 1: reset with random inputs, then all request: source 0 first.
    do_reset();
    drive(1'b0, 4'b1111, 1'b1);
    check("rst_m_vaild", 64'(m_vaild), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_id", 64'(m_id), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    cycle();
    drive(1'b0, 4'b1111, 1'b1);
    check("first_grant", 64'(s_ready), 64'b0001);
    cycle();

    // 2: single source 1, 0x10.. ; 8 beats in 10 cycles.
    do_reset();
    seq[1] = 0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 4'b0010, 1'b1);
      if (s_vaild[1] && s_ready[1]) cnt++;
      cycle();
    end
    check("single_beats", 64'(cnt), 64'd8);
    drive(1'b0, 4'b0000, 1'b1);
    check("single_last", 64'(m_data), 64'h17);
    cycle();

    // 3: all sources, 20 beats in 25 cycles.
    do_reset();
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      drive(1'b0, 4'b1111, 1'b1);
      if ((s_vaild & s_ready) != '0) cnt++;
      cycle();
    end
    check("all_beats", 64'(cnt), 64'd20);

    // 4: backpressure after the first beat of source 0.
    do_reset();
    drive(1'b0, 4'b0001, 1'b1); cycle();
    drive(1'b0, 4'b0001, 1'b1); cycle();
    held_d  = m_data;
    held_id = m_id;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b0001, 1'b0);
      check("bp_m_vaild", 64'(m_vaild), 64'd1);
      check("bp_m_data", 64'(m_data), 64'(held_d));
      check("bp_m_id", 64'(m_id), 64'(held_id));
      check("bp_s_ready", 64'(s_ready), 64'd0);
      cycle();
    end
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'b0001, 1'b1); cycle();
    end

    // 5: early release of source 2 while 3 requests.
    do_reset();
    drive(1'b0, 4'b1100, 1'b1); cycle();
    drive(1'b0, 4'b1100, 1'b1); cycle();
    drive(1'b0, 4'b1100, 1'b1); cycle();
    drive(1'b0, 4'b1000, 1'b1);
    check("early_rel_rdy", 64'(s_ready), 64'b0100);
    cycle();
    drive(1'b0, 4'b1000, 1'b1);
    check("early_idle", 64'(s_ready), 64'd0);
    cycle();
    drive(1'b0, 4'b1000, 1'b1);
    check("early_next", 64'(s_ready), 64'b1000);
    cycle();

    // 6: reset after two beats of a source 0 burst; beat in that cycle dropped.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'b1111, 1'b1); cycle();
    end
    drive(1'b1, 4'b1111, 1'b1); cycle();
    drive(1'b0, 4'b1111, 1'b1);
    check("midrst_m_vaild", 64'(m_vaild), 64'd0);
    check("midrst_idle", 64'(s_ready), 64'd0);
    cycle();
    drive(1'b0, 4'b1111, 1'b1);
    check("midrst_regrant", 64'(s_ready), 64'b0001);
    cycle();

    // Random traffic with sticky valids, random backpressure and rare resets.
    vld = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) vld[i] = ~vld[i];
      drive(($urandom_range(199) == 0), vld, ($urandom_range(3) != 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
